// File: rtl/booth_mult_seq_if.sv
// Handshake/data bundle for the sequential Booth multiplier.
// The master drives the start pulse and operands; the slave returns the result, its flags and busy.
interface booth_mult_seq_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (output ctrl_MULT, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY, busy);
  modport slave  (input  ctrl_MULT, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY, busy);
endinterface

// File: rtl/booth_mult_seq.sv
// Iterative signed multiplier using radix-4 modified Booth recoding (2 multiplier bits per cycle).
// The result and overflow flag are registered when DONE is entered and held until the next DONE.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic             clock,
  input logic             reset,
  booth_mult_seq_if.slave bus
);
  localparam int AW = WIDTH + 2;     // accumulator width; leaves headroom for -2M of the most negative M
  localparam int PW = AW + WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);
  localparam logic [AW-1:0]    ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [PW-1:0]    p;               // {acc, Q, q-1}
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0] mext, m2, addend, sum;
  logic [PW-1:0] pn;
  logic [WIDTH:0] hi;

  assign mext = {{2{m[WIDTH-1]}}, m};
  assign m2   = {mext[AW-2:0], 1'b0};

  always_comb begin
    addend = '0;
    unique case (p[2:0])
      3'b001, 3'b010: addend = mext;
      3'b011:         addend = m2;
      3'b100:         addend = ~m2 + ONE;
      3'b101, 3'b110: addend = ~mext + ONE;
      default:        addend = '0;
    endcase
  end

  assign sum = p[PW-1:PW-AW] + addend;
  assign pn  = {{2{sum[AW-1]}}, sum, p[WIDTH:2]};
  // Product bits [2W-1:W-1] of the completed product; they must all match for no overflow.
  assign hi  = pn[2*WIDTH:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      m                  <= '0;
      p                  <= '0;
      cnt                <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      // A start in any state (including mid-RUN abort) relatches operands.
      state              <= RUN;
      m                  <= bus.data_operandA;
      p                  <= {{AW{1'b0}}, bus.data_operandB, 1'b0};
      cnt                <= '0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          bus.data_resultRDY <= 1'b0;
          bus.busy           <= 1'b0;
        end
        RUN: begin
          p   <= pn;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state              <= DONE;
            bus.data_result    <= pn[WIDTH:1];
            bus.data_exception <= ~((&hi) | ~(|hi));
            bus.data_resultRDY <= 1'b1;
            bus.busy           <= 1'b0;
          end
        end
        DONE: begin
          state              <= IDLE;
          bus.data_resultRDY <= 1'b0;
          bus.busy           <= 1'b0;
        end
        default: begin
          state              <= IDLE;
          bus.data_resultRDY <= 1'b0;
          bus.busy           <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq against a plain 64-bit signed multiply model.
module tb_booth_mult_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errs   = 0;
  int   overlap = 0;

  booth_mult_seq_if #(.WIDTH(32)) bus ();
  booth_mult_seq #(.WIDTH(32), .CNT_W(5)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_mult(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc);
    longint prod;
    prod = longint'(signed'(a)) * longint'(signed'(b));
    res  = prod[31:0];
    exc  = (prod != longint'(signed'(res)));
  endtask

  // chain=1: drive the start on the current negedge (used from DONE or mid-RUN).
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit chain, input bit hold);
    logic [31:0] er;
    logic        ee;
    int          n;
    ref_mult(a, b, er, ee);
    if (!chain) @(negedge clock);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = a; bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0; bus.data_operandA = $urandom; bus.data_operandB = $urandom;
    n = 0;
    while (bus.busy && n < 40) begin
      if (bus.data_resultRDY) overlap++;
      @(negedge clock);
      n++;
    end
    chk("busy_cycles", 64'(n), 64'd16);
    chk("rdy_pulse", 64'(bus.data_resultRDY), 64'd1);
    chk("result", 64'(bus.data_result), 64'(er));
    chk("exception", 64'(bus.data_exception), 64'(ee));
    if (hold) begin
      @(negedge clock);
      chk("rdy_low_after", 64'(bus.data_resultRDY), 64'd0);
      chk("busy_low_after", 64'(bus.busy), 64'd0);
      chk("result_held", 64'(bus.data_result), 64'(er));
      chk("exc_held", 64'(bus.data_exception), 64'(ee));
    end
  endtask

  initial begin
    int rdy_seen;
    logic [31:0] a, b;
    bus.ctrl_MULT = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    #1;
    chk("reset_result", 64'(bus.data_result), 64'd0);
    chk("reset_exc", 64'(bus.data_exception), 64'd0);
    chk("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    do_mult(32'd3, 32'd5, 0, 1);
    do_mult(32'hFFFFFFF9, 32'd6, 0, 1);
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    do_mult(32'h7FFFFFFF, 32'd2, 0, 0);
    do_mult(32'h80000000, 32'hFFFFFFFF, 0, 0);
    do_mult(32'h80000000, 32'd1, 0, 0);
    do_mult(32'hFFFF0000, 32'h00010000, 0, 0);
    do_mult(32'h00010000, 32'h00008000, 0, 0);
    do_mult(32'h80000000, 32'h80000000, 0, 0);
    do_mult(32'h7FFFFFFF, 32'h80000000, 0, 0);

    // Abort mid-RUN: only the second operation may produce a pulse.
    @(negedge clock);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd5;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    rdy_seen = 0;
    repeat (6) begin
      if (bus.data_resultRDY) rdy_seen++;
      @(negedge clock);
    end
    chk("abort_no_rdy", 64'(rdy_seen), 64'd0);
    do_mult(32'd4, 32'd4, 1, 1);

    // Start issued during the DONE cycle.
    do_mult(32'd1234, 32'hFFFFF000, 0, 0);
    do_mult(32'h00012345, 32'h00000777, 1, 1);

    // Async reset between edges in RUN.
    @(negedge clock);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_result", 64'(bus.data_result), 64'd0);
    chk("arst_exc", 64'(bus.data_exception), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_rdy", 64'(bus.data_resultRDY), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    repeat (20) begin
      if (bus.data_resultRDY || bus.busy) rdy_seen++;
      @(negedge clock);
    end
    chk("arst_quiet", 64'(rdy_seen), 64'd0);
    do_mult(32'hFFFFFFF9, 32'd6, 0, 1);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = {{16{a[15]}}, a[15:0]};
      if (i % 4 == 2) b = {{20{b[11]}}, b[11:0]};
      do_mult(a, b, $urandom_range(0, 1) == 1, 0);
    end

    chk("rdy_busy_overlap", 64'(overlap), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
